// File: rtl/int_scheduler_pkg.sv
// Shared definitions for the interrupt scheduler: FSM encoding, vector
// defaults and a priority (highest set bit) helper.
package int_scheduler_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_VECTOR = 2'd2,
      ST_RETURN = 2'd3
   } sched_state_e;

   localparam logic [31:0] VEC_BASE_DEF   = 32'h0000_0100;
   localparam logic [31:0] VEC_STRIDE_DEF = 32'h0000_0010;

   // Index of the highest set bit; 0 when the vector is empty, so callers
   // must qualify the result with a non-zero test.
   function automatic logic [4:0] hsb_idx(input logic [31:0] v);
      logic [4:0] r;
      r = '0;
      for (int i = 0; i < 32; i++) begin
         if (v[i]) r = 5'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/irq_epc_stack.sv
// LIFO of saved return addresses, one slot per nesting level.
module irq_epc_stack #(
   parameter int DEPTH = 3
) (
   input  logic        clk,
   input  logic        rst_ni,
   input  logic        push_i,
   input  logic        pop_i,
   input  logic [31:0] data_i,
   output logic [31:0] top_o,
   output logic        empty_o
);

   localparam int SP_W = $clog2(DEPTH + 1);

   logic [SP_W-1:0] sp_q, sp_d;
   logic [31:0]     mem_q [DEPTH];

   always_comb begin
      sp_d = sp_q;
      if (push_i && (sp_q != SP_W'(DEPTH))) begin
         sp_d = sp_q + 1'b1;
      end else if (pop_i && (sp_q != '0)) begin
         sp_d = sp_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_ni) begin
         sp_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         sp_q <= sp_d;
         for (int i = 0; i < DEPTH; i++) begin
            if (push_i && (sp_q == SP_W'(i))) mem_q[i] <= data_i;
         end
      end
   end

   always_comb begin
      top_o = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (sp_q == SP_W'(i + 1)) top_o = mem_q[i];
      end
   end

   assign empty_o = (sp_q == '0);

endmodule

// File: rtl/int_scheduler.sv
// Prioritised, nestable interrupt scheduler: latches request edges, drains
// the pipeline, vectors the PC and restores it on eret.
module int_scheduler
   import int_scheduler_pkg::*;
#(
   parameter int          N_IRQ      = 3,
   parameter logic [31:0] VEC_BASE   = VEC_BASE_DEF,
   parameter logic [31:0] VEC_STRIDE = VEC_STRIDE_DEF
) (
   input  logic             clk,
   input  logic             RST,
   input  logic [N_IRQ-1:0] irq_in,
   input  logic             mask_we,
   input  logic [N_IRQ-1:0] mask_wdata,
   input  logic             int_en,
   input  logic             pipe_safe,
   input  logic [31:0]      pc_ex,
   input  logic             eret,
   output logic             flush,
   output logic             pc_load,
   output logic [31:0]      pc_target,
   output logic [N_IRQ-1:0] pending,
   output logic [N_IRQ-1:0] in_service,
   output logic [N_IRQ-1:0] mask,
   output logic             busy
);

   localparam int IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

   sched_state_e     state_q, state_d;
   logic [N_IRQ-1:0] pending_q, pending_d;
   logic [N_IRQ-1:0] in_service_q, in_service_d;
   logic [N_IRQ-1:0] mask_q, mask_d;
   logic [N_IRQ-1:0] prev_irq_q;
   logic             armed_q;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [31:0]      epc_q, epc_d;
   logic [31:0]      pc_target_q, pc_target_d;

   logic [N_IRQ-1:0] edges, elig, pending_clr, isr_set, isr_clr;
   logic [4:0]       elig_top, isr_top;
   logic             accept;
   logic             stk_push, stk_pop, stk_empty;
   logic [31:0]      stk_top;

   // armed_q keeps the first post-reset sample from looking like an edge,
   // so a line held high across reset release does not fire.
   assign edges    = irq_in & ~prev_irq_q & {N_IRQ{armed_q}};
   assign elig     = pending_q & mask_q & {N_IRQ{int_en}};
   assign elig_top = hsb_idx(32'(elig));
   assign isr_top  = hsb_idx(32'(in_service_q));
   assign accept   = (elig != '0) && ((in_service_q == '0) || (elig_top > isr_top));

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      epc_d       = epc_q;
      pc_target_d = pc_target_q;
      pending_clr = '0;
      isr_set     = '0;
      isr_clr     = '0;
      stk_push    = 1'b0;
      stk_pop     = 1'b0;
      flush       = 1'b0;
      pc_load     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (eret) begin
               state_d = ST_RETURN;
               if (!stk_empty) pc_target_d = stk_top;
            end else if (accept) begin
               idx_d   = elig_top[IDX_W-1:0];
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            flush = 1'b1;
            if (!mask_q[idx_q] || !int_en) begin
               state_d = ST_IDLE;
            end else if (pipe_safe) begin
               epc_d       = pc_ex + 32'd1;
               pc_target_d = VEC_BASE + 32'(idx_q) * VEC_STRIDE;
               state_d     = ST_VECTOR;
            end
         end
         ST_VECTOR: begin
            flush              = 1'b1;
            pc_load            = 1'b1;
            stk_push           = 1'b1;
            isr_set[idx_q]     = 1'b1;
            pending_clr[idx_q] = 1'b1;
            state_d            = ST_IDLE;
         end
         ST_RETURN: begin
            // A spurious eret (empty stack) leaves the PC alone.
            if (!stk_empty) begin
               flush                       = 1'b1;
               pc_load                     = 1'b1;
               stk_pop                     = 1'b1;
               isr_clr[isr_top[IDX_W-1:0]] = 1'b1;
            end
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // A new edge wins over the clear issued while vectoring.
   assign pending_d    = (pending_q & ~pending_clr) | edges;
   assign in_service_d = (in_service_q | isr_set) & ~isr_clr;
   assign mask_d       = mask_we ? mask_wdata : mask_q;

   always_ff @(posedge clk) begin
      if (!RST) begin
         state_q      <= ST_IDLE;
         pending_q    <= '0;
         in_service_q <= '0;
         mask_q       <= '1;
         prev_irq_q   <= '0;
         armed_q      <= 1'b0;
         idx_q        <= '0;
         epc_q        <= '0;
         pc_target_q  <= '0;
      end else begin
         state_q      <= state_d;
         pending_q    <= pending_d;
         in_service_q <= in_service_d;
         mask_q       <= mask_d;
         prev_irq_q   <= irq_in;
         armed_q      <= 1'b1;
         idx_q        <= idx_d;
         epc_q        <= epc_d;
         pc_target_q  <= pc_target_d;
      end
   end

   irq_epc_stack #(.DEPTH(N_IRQ)) u_stack (
      .clk     (clk),
      .rst_ni  (RST),
      .push_i  (stk_push),
      .pop_i   (stk_pop),
      .data_i  (epc_q),
      .top_o   (stk_top),
      .empty_o (stk_empty)
   );

   assign pc_target  = pc_target_q;
   assign pending    = pending_q;
   assign in_service = in_service_q;
   assign mask       = mask_q;
   assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_int_scheduler.sv
// Bench for int_scheduler: directed scenarios with literal expectations plus
// random traffic, all cross-checked every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_int_scheduler;

   localparam int          N          = 3;
   localparam logic [31:0] VEC_BASE   = 32'h0000_0100;
   localparam logic [31:0] VEC_STRIDE = 32'h0000_0010;

   logic          clk = 1'b0;
   logic          RST;
   logic [N-1:0]  irq_in;
   logic          mask_we;
   logic [N-1:0]  mask_wdata;
   logic          int_en;
   logic          pipe_safe;
   logic [31:0]   pc_ex;
   logic          eret;
   logic          flush, pc_load, busy;
   logic [31:0]   pc_target;
   logic [N-1:0]  pending, in_service, mask;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   int_scheduler #(.N_IRQ(N), .VEC_BASE(VEC_BASE), .VEC_STRIDE(VEC_STRIDE)) dut (
      .clk        (clk),
      .RST        (RST),
      .irq_in     (irq_in),
      .mask_we    (mask_we),
      .mask_wdata (mask_wdata),
      .int_en     (int_en),
      .pipe_safe  (pipe_safe),
      .pc_ex      (pc_ex),
      .eret       (eret),
      .flush      (flush),
      .pc_load    (pc_load),
      .pc_target  (pc_target),
      .pending    (pending),
      .in_service (in_service),
      .mask       (mask),
      .busy       (busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Phase: 0 idle, 1 draining, 2 vectoring, 3 returning.
   logic [N-1:0] m_pending, m_isr, m_mask, m_prev;
   bit           m_prev_ok, m_ret_load;
   int           m_phase, m_idx;
   logic [31:0]  m_epc, m_target;
   logic [31:0]  m_stack[$];

   function automatic int hi(input logic [N-1:0] v);
      int r = -1;
      for (int i = 0; i < N; i++) if (v[i]) r = i;
      return r;
   endfunction

   always @(posedge clk) begin
      logic [N-1:0] rise;
      int e, s;
      if (!RST) begin
         m_pending = '0; m_isr = '0; m_mask = '1; m_prev = '0; m_prev_ok = 0;
         m_ret_load = 0; m_phase = 0; m_idx = 0; m_epc = '0; m_target = '0;
         m_stack.delete();
      end else begin
         rise = m_prev_ok ? (irq_in & ~m_prev) : '0;
         case (m_phase)
            0: begin
               if (eret) begin
                  m_phase    = 3;
                  m_ret_load = (m_stack.size() > 0);
                  if (m_ret_load) m_target = m_stack[$];
               end else begin
                  e = hi(m_pending & m_mask & {N{int_en}});
                  s = hi(m_isr);
                  if (e >= 0 && e > s) begin
                     m_idx   = e;
                     m_phase = 1;
                  end
               end
            end
            1: begin
               if (!m_mask[m_idx] || !int_en) m_phase = 0;
               else if (pipe_safe) begin
                  m_epc    = pc_ex + 32'd1;
                  m_target = VEC_BASE + 32'(m_idx) * VEC_STRIDE;
                  m_phase  = 2;
               end
            end
            2: begin
               m_stack.push_back(m_epc);
               m_isr[m_idx]     = 1'b1;
               m_pending[m_idx] = 1'b0;
               m_phase          = 0;
            end
            default: begin
               if (m_ret_load) begin
                  void'(m_stack.pop_back());
                  s = hi(m_isr);
                  if (s >= 0) m_isr[s] = 1'b0;
               end
               m_ret_load = 0;
               m_phase    = 0;
            end
         endcase
         m_pending = m_pending | rise;
         if (mask_we) m_mask = mask_wdata;
         m_prev    = irq_in;
         m_prev_ok = 1;
      end
   end

   // Compare every cycle, shortly after the active edge.
   always @(posedge clk) begin
      bit e_flush, e_load;
      #1;
      e_load  = (m_phase == 2) || (m_phase == 3 && m_ret_load);
      e_flush = (m_phase == 1) || e_load;
      chk("m_flush",      32'(flush),      32'(e_flush));
      chk("m_pc_load",    32'(pc_load),    32'(e_load));
      chk("m_pc_target",  pc_target,       m_target);
      chk("m_pending",    32'(pending),    32'(m_pending));
      chk("m_in_service", 32'(in_service), 32'(m_isr));
      chk("m_mask",       32'(mask),       32'(m_mask));
      chk("m_busy",       32'(busy),       32'(m_phase != 0));
   end

   // ---------------- directed helpers ----------------
   task automatic step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      RST = 1'b0; step();
      RST = 1'b1; step();
   endtask

   task automatic pulse_irq(input int i);
      irq_in[i] = 1'b1; step();
      irq_in[i] = 1'b0;
   endtask

   task automatic do_eret();
      eret = 1'b1; step();
      eret = 1'b0;
   endtask

   task automatic wait_load(input string name, input logic [31:0] exp);
      bit seen = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
         step();
         if (pc_load) begin
            seen = 1;
            chk(name, pc_target, exp);
         end
      end
      if (!seen) chk({name, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic take(input int i, input logic [31:0] pc, input logic [31:0] exp, input string name);
      pc_ex = pc;
      pulse_irq(i);
      wait_load(name, exp);
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      RST = 1'b0; irq_in = '0; mask_we = 1'b0; mask_wdata = '0; int_en = 1'b1;
      pipe_safe = 1'b1; pc_ex = 32'h40; eret = 1'b0;
      step(); step();
      chk("rst_pending", 32'(pending), 32'h0);
      chk("rst_mask",    32'(mask),    32'h7);
      chk("rst_busy",    32'(busy),    32'h0);
      chk("rst_target",  pc_target,    32'h0);
      RST = 1'b1; step();

      // Single IRQ then return.
      pulse_irq(1);
      chk("s1_pending", 32'(pending), 32'h2);
      step();
      chk("s1_drain_flush", 32'(flush), 32'h1);
      chk("s1_drain_load",  32'(pc_load), 32'h0);
      step();
      chk("s1_vec_load",   32'(pc_load), 32'h1);
      chk("s1_vec_target", pc_target,    32'h110);
      chk("s1_vec_flush",  32'(flush),   32'h1);
      step();
      chk("s1_isr",      32'(in_service), 32'h2);
      chk("s1_pend_clr", 32'(pending),    32'h0);
      chk("s1_flush_off", 32'(flush),     32'h0);
      do_eret();
      chk("s2_load",   32'(pc_load), 32'h1);
      chk("s2_target", pc_target,    32'h41);
      chk("s2_flush",  32'(flush),   32'h1);
      step();
      chk("s2_isr",  32'(in_service), 32'h0);
      chk("s2_busy", 32'(busy),       32'h0);

      // Nesting.
      do_reset();
      take(0, 32'h1F, 32'h100, "nest_v0");
      chk("nest_isr1", 32'(in_service), 32'h1);
      take(2, 32'h104, 32'h120, "nest_v2");
      chk("nest_isr5", 32'(in_service), 32'h5);
      do_eret();
      chk("nest_ret1", pc_target, 32'h105);
      step();
      do_eret();
      chk("nest_ret2", pc_target, 32'h20);
      step();
      chk("nest_isr0", 32'(in_service), 32'h0);

      // Lower priority request while a higher handler runs.
      do_reset();
      take(1, 32'h40, 32'h110, "prio_v1");
      pulse_irq(0);
      for (int k = 0; k < 4; k++) begin
         step();
         chk("prio_no_drain", 32'(busy), 32'h0);
      end
      chk("prio_pending", 32'(pending), 32'h1);

      // Mask.
      do_reset();
      mask_we = 1'b1; mask_wdata = 3'b011; step();
      mask_we = 1'b0;
      chk("mask_val", 32'(mask), 32'h3);
      pulse_irq(2);
      chk("mask_pending", 32'(pending), 32'h4);
      for (int k = 0; k < 3; k++) begin
         step();
         chk("mask_no_flush", 32'(flush), 32'h0);
      end
      mask_we = 1'b1; mask_wdata = 3'b111; step();
      mask_we = 1'b0;
      wait_load("mask_vec", 32'h120);
      step();

      // Drain stall.
      do_reset();
      pipe_safe = 1'b0;
      pulse_irq(1);
      for (int k = 0; k < 5; k++) begin
         step();
         chk("stall_flush", 32'(flush),   32'h1);
         chk("stall_load",  32'(pc_load), 32'h0);
      end
      pipe_safe = 1'b1;
      wait_load("stall_vec", 32'h110);
      step();

      // int_en drop during drain.
      do_reset();
      pipe_safe = 1'b0;
      pulse_irq(1);
      step();
      chk("en_drain", 32'(busy), 32'h1);
      int_en = 1'b0; step();
      chk("en_abort",   32'(busy),    32'h0);
      chk("en_pending", 32'(pending), 32'h2);
      int_en = 1'b1; pipe_safe = 1'b1;

      // eret and eligible request together.
      do_reset();
      take(0, 32'h1F, 32'h100, "sim_v0");
      irq_in[1] = 1'b1; step();
      irq_in[1] = 1'b0; eret = 1'b1; step();
      eret = 1'b0;
      chk("sim_ret_load",   32'(pc_load), 32'h1);
      chk("sim_ret_target", pc_target,    32'h20);
      step();
      chk("sim_idle",    32'(busy),       32'h0);
      chk("sim_pending", 32'(pending),    32'h2);
      chk("sim_isr",     32'(in_service), 32'h0);
      step();
      chk("sim_drain", 32'(flush), 32'h1);
      wait_load("sim_vec", 32'h110);
      step();

      // Reset during drain, with a line held high across release.
      pipe_safe = 1'b0;
      pulse_irq(2);
      step();
      chk("rmid_drain", 32'(flush), 32'h1);
      irq_in[2] = 1'b1; RST = 1'b0; step();
      chk("rmid_flush",  32'(flush),      32'h0);
      chk("rmid_load",   32'(pc_load),    32'h0);
      chk("rmid_target", pc_target,       32'h0);
      chk("rmid_pend",   32'(pending),    32'h0);
      chk("rmid_isr",    32'(in_service), 32'h0);
      chk("rmid_mask",   32'(mask),       32'h7);
      chk("rmid_busy",   32'(busy),       32'h0);
      RST = 1'b1;
      for (int k = 0; k < 4; k++) step();
      chk("rmid_held_pend", 32'(pending), 32'h0);
      chk("rmid_held_busy", 32'(busy),    32'h0);
      irq_in = '0; pipe_safe = 1'b1;

      // Spurious eret.
      do_reset();
      do_eret();
      chk("spur_load",  32'(pc_load), 32'h0);
      chk("spur_flush", 32'(flush),   32'h0);
      chk("spur_busy",  32'(busy),    32'h1);
      step();
      chk("spur_idle", 32'(busy), 32'h0);

      // Random traffic, checked by the model only.
      for (int c = 0; c < 4000; c++) begin
         RST = ($urandom_range(0, 199) != 0);
         for (int b = 0; b < N; b++) begin
            if ($urandom_range(0, 7) == 0) irq_in[b] = ~irq_in[b];
         end
         mask_we    = ($urandom_range(0, 31) == 0);
         mask_wdata = N'($urandom);
         int_en     = ($urandom_range(0, 15) != 0);
         pipe_safe  = ($urandom_range(0, 3) != 0);
         pc_ex      = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : $urandom;
         eret       = ($urandom_range(0, 11) == 0);
         step();
      end
      RST = 1'b1; eret = 1'b0; mask_we = 1'b0;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
